// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit shifters.
//   PAR_*              : parity_type encodings (2'b11 behaves as no parity)
//   rx_state_e         : receiver state encoding
//   OVERSAMPLE_DEFAULT : default baud ticks per bit
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_DONE
  } rx_state_e;

endpackage

// File: rtl/uart_sipo_if.sv
// Receiver line/config/result bundle.
//   data_in, parity_type, stop_bits, data_length : line and frame config
//   data_out, rx_active, rx_done, parity_error, stop_error : results
// master drives the line and config; slave is the receiver.
interface uart_sipo_if;
  logic       data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_in, parity_type, stop_bits, data_length,
    input  data_out, rx_active, rx_done, parity_error, stop_error
  );

  modport slave (
    input  data_in, parity_type, stop_bits, data_length,
    output data_out, rx_active, rx_done, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous line input, reset to 1 (idle).
//   clk      : destination clock
//   rst      : asynchronous active-high reset
//   async_in : raw asynchronous input
//   sync_out : synchronized output, two cycles of latency
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_sipo.sv
// Serial-in/parallel-out UART receiver: start, 7/8 data bits MSB first,
// optional parity, 1/2 stop bits, sampled mid-bit on an oversampled tick.
//   baud_out : sole clock, OVERSAMPLE x bit rate
//   rst      : asynchronous active-high reset
//   rx       : line/config inputs and received word/status outputs
module uart_sipo
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic        baud_out,
  input  logic        rst,
  uart_sipo_if.slave  rx
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);

  logic rxs;

  uart_rx_sync u_sync (
    .clk      (baud_out),
    .rst      (rst),
    .async_in (rx.data_in),
    .sync_out (rxs)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_acc_q, par_acc_d;
  logic [1:0]    cfg_par_q, cfg_par_d;
  logic          cfg_stop_q, cfg_stop_d;
  logic          cfg_len_q, cfg_len_d;
  logic          armed_q, armed_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          rx_active_q, rx_active_d;
  logic          rx_done_q, rx_done_d;
  logic          perr_q, perr_d;
  logic          serr_q, serr_d;

  logic par_en;
  assign par_en = (cfg_par_q == PAR_ODD) || (cfg_par_q == PAR_EVEN);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    cfg_par_d   = cfg_par_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_len_d   = cfg_len_q;
    armed_d     = armed_q | rxs;
    data_out_d  = data_out_q;
    rx_active_d = rx_active_q;
    rx_done_d   = 1'b0;
    perr_d      = perr_q;
    serr_d      = serr_q;

    unique case (state_q)
      // armed_q stands in for the previous-sample edge detector: it remembers
      // that the line has been high since the last frame, so a fall landing in
      // the DONE cycle is still seen, and a line held low never retriggers.
      RX_IDLE: begin
        if (!rxs && armed_q) begin
          state_d    = RX_START;
          tick_d     = '0;
          armed_d    = 1'b0;
          cfg_par_d  = rx.parity_type;
          cfg_stop_d = rx.stop_bits;
          cfg_len_d  = rx.data_length;
        end
      end
      RX_START: begin
        if (tick_q == HALF_TICK) begin
          tick_d = '0;
          if (!rxs) begin
            state_d     = RX_DATA;
            rx_active_d = 1'b1;
            perr_d      = 1'b0;
            serr_d      = 1'b0;
            shift_d     = '0;
            par_acc_d   = 1'b0;
            bit_d       = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (tick_q == FULL_TICK) begin
          tick_d    = '0;
          shift_d   = {shift_q[6:0], rxs};
          par_acc_d = par_acc_q ^ rxs;
          if (bit_q == (cfg_len_q ? 4'd7 : 4'd6)) begin
            bit_d   = '0;
            state_d = par_en ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (tick_q == FULL_TICK) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = RX_STOP;
          perr_d  = (cfg_par_q == PAR_ODD) ? ~(par_acc_q ^ rxs) : (par_acc_q ^ rxs);
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (tick_q == FULL_TICK) begin
          tick_d = '0;
          if (!rxs) serr_d = 1'b1;
          if (bit_q == {3'b000, cfg_stop_q}) begin
            // Results are registered here so they are visible in the DONE cycle.
            state_d     = RX_DONE;
            data_out_d  = shift_q;
            rx_done_d   = 1'b1;
            rx_active_d = 1'b0;
            armed_d     = rxs;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RX_DONE: begin
        state_d = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_out or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      cfg_par_q   <= PAR_NONE;
      cfg_stop_q  <= 1'b0;
      cfg_len_q   <= 1'b0;
      armed_q     <= 1'b0;
      data_out_q  <= '0;
      rx_active_q <= 1'b0;
      rx_done_q   <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      cfg_par_q   <= cfg_par_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_len_q   <= cfg_len_d;
      armed_q     <= armed_d;
      data_out_q  <= data_out_d;
      rx_active_q <= rx_active_d;
      rx_done_q   <= rx_done_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  assign rx.data_out     = data_out_q;
  assign rx.rx_active    = rx_active_q;
  assign rx.rx_done      = rx_done_q;
  assign rx.parity_error = perr_q;
  assign rx.stop_error   = serr_q;

endmodule

// File: tb/tb_uart_sipo.sv
// Directed bench for uart_sipo: table of frames plus hand-written sequences
// for false start, hold-low, reset mid-frame, config change and back-to-back.
module tb_uart_sipo;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_sipo_if ifc ();

  uart_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_out (clk),
    .rst      (rst),
    .rx       (ifc)
  );

  typedef struct {
    logic [1:0] pt;
    logic       sb;
    logic       dl;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;   // bit 0 is the first stop bit on the line
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_serr;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [7:0] last_data;
  logic       last_perr;
  logic       last_serr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame from the first negedge (start bit), then tail cycles of
  // tail_val. Observed values are tagged with the posedge index P(k) where P0
  // is the first posedge after the raw falling edge.
  task automatic run_frame(input vec_t v, input int tail, input logic tail_val,
                           input int flip_at, input string name);
    logic line [0:11];
    int nd, np, ns, n, total, slot;
    int done_cnt, done_at, act_at, act_after;
    logic [7:0] cap_data;
    logic cap_perr, cap_serr;
    nd = v.dl ? 8 : 7;
    np = (v.pt == 2'b01 || v.pt == 2'b10) ? 1 : 0;
    ns = v.sb ? 2 : 1;
    n  = nd + np + ns;
    for (int j = 0; j < 12; j++) line[j] = 1'b1;
    for (int j = 0; j < nd; j++) line[j] = v.data[nd-1-j];
    if (np == 1) line[nd] = v.pbit;
    for (int j = 0; j < ns; j++) line[nd+np+j] = v.stops[j];
    total = (n + 1) * OS + tail;
    done_cnt = 0; done_at = -1; act_at = -1; act_after = 0;
    cap_data = '0; cap_perr = 1'b0; cap_serr = 1'b0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ifc.parity_type = v.pt;
        ifc.stop_bits   = v.sb;
        ifc.data_length = v.dl;
      end else begin
        if (ifc.rx_done) begin
          done_cnt++;
          if (done_cnt == 1) begin
            done_at  = i - 1;
            cap_data = ifc.data_out;
            cap_perr = ifc.parity_error;
            cap_serr = ifc.stop_error;
          end
        end
        if (ifc.rx_active && act_at < 0) act_at = i - 1;
        if (ifc.rx_active && done_cnt > 0) act_after++;
      end
      if (i == flip_at) ifc.data_length = ~ifc.data_length;
      slot = i / OS;
      ifc.data_in = (slot == 0) ? 1'b0 : (slot <= n) ? line[slot-1] : tail_val;
    end
    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " done_cycle"}, done_at, n * OS + OS / 2 + 2);
    chk({name, " active_rise"}, act_at, OS / 2 + 2);
    chk({name, " active_after_done"}, act_after, 0);
    chk({name, " data_out"}, cap_data, v.e_data);
    chk({name, " parity_error"}, cap_perr, v.e_perr);
    chk({name, " stop_error"}, cap_serr, v.e_serr);
    chk({name, " data_hold"}, ifc.data_out, v.e_data);
    last_data = v.e_data;
    last_perr = v.e_perr;
    last_serr = v.e_serr;
  endtask

  task automatic idle_high(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ifc.data_in = 1'b1;
    end
  endtask

  vec_t vecs [9];
  vec_t v;
  int   act_cnt, done_cnt;

  initial begin
    //            pt     sb    dl    data   pbit  stops  e_data e_perr e_serr
    vecs[0] = '{2'b10, 1'b0, 1'b1, 8'hA5, 1'b0, 2'b01, 8'hA5, 1'b0, 1'b0}; // 8E1
    vecs[1] = '{2'b01, 1'b1, 1'b0, 8'h2B, 1'b0, 2'b11, 8'h2B, 1'b1, 1'b0}; // 7O2 bad parity
    vecs[2] = '{2'b01, 1'b0, 1'b1, 8'h00, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0}; // 8O1
    vecs[3] = '{2'b10, 1'b0, 1'b1, 8'hFF, 1'b1, 2'b01, 8'hFF, 1'b1, 1'b0}; // 8E1 bad parity
    vecs[4] = '{2'b00, 1'b0, 1'b1, 8'h81, 1'b0, 2'b00, 8'h81, 1'b0, 1'b1}; // 8N1 stop low
    vecs[5] = '{2'b10, 1'b0, 1'b0, 8'h7F, 1'b1, 2'b01, 8'h7F, 1'b0, 1'b0}; // 7E1
    vecs[6] = '{2'b11, 1'b0, 1'b1, 8'h5A, 1'b1, 2'b01, 8'h5A, 1'b0, 1'b0}; // 2'b11 = none
    vecs[7] = '{2'b00, 1'b1, 1'b1, 8'hC3, 1'b0, 2'b10, 8'hC3, 1'b0, 1'b1}; // 8N2 first stop low
    vecs[8] = '{2'b00, 1'b0, 1'b0, 8'hD5, 1'b0, 2'b01, 8'h55, 1'b0, 1'b0}; // 7N1 right-aligned

    rst = 1'b1;
    ifc.data_in = 1'b1;
    ifc.parity_type = 2'b00;
    ifc.stop_bits = 1'b0;
    ifc.data_length = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset data_out", ifc.data_out, 8'h00);
    chk("reset rx_active", ifc.rx_active, 1'b0);
    chk("reset rx_done", ifc.rx_done, 1'b0);
    chk("reset parity_error", ifc.parity_error, 1'b0);
    chk("reset stop_error", ifc.stop_error, 1'b0);
    rst = 1'b0;
    idle_high(4);

    for (int k = 0; k < 9; k++) begin
      run_frame(vecs[k], OS, 1'b1, -1, $sformatf("vec%0d", k));
      idle_high(3);
    end

    // False start: 4 ticks low, then high.
    act_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3 * OS; i++) begin
      @(negedge clk);
      if (ifc.rx_active) act_cnt++;
      if (ifc.rx_done) done_cnt++;
      ifc.data_in = (i < 4) ? 1'b0 : 1'b1;
    end
    chk("false_start active", act_cnt, 0);
    chk("false_start done", done_cnt, 0);
    chk("false_start data_hold", ifc.data_out, last_data);
    chk("false_start perr_hold", ifc.parity_error, last_perr);
    chk("false_start serr_hold", ifc.stop_error, last_serr);

    // 8N2 with second stop low, line then held low: no retrigger.
    v = '{2'b00, 1'b1, 1'b1, 8'h6E, 1'b0, 2'b01, 8'h6E, 1'b0, 1'b1};
    run_frame(v, 4 * OS, 1'b0, -1, "8n2_hold_low");
    idle_high(OS);
    v = '{2'b00, 1'b0, 1'b1, 8'h17, 1'b0, 2'b01, 8'h17, 1'b0, 1'b0};
    run_frame(v, OS, 1'b1, -1, "after_hold_low");

    // Reset during data bit 4 of an 8N1 frame carrying 0xA5.
    act_cnt = 0; done_cnt = 0;
    ifc.parity_type = 2'b00; ifc.stop_bits = 1'b0; ifc.data_length = 1'b1;
    begin
      logic [7:0] w;
      w = 8'hA5;
      for (int i = 0; i < 4 * OS + 8; i++) begin
        @(negedge clk);
        if (ifc.rx_done) done_cnt++;
        if (ifc.rx_active) act_cnt++;
        ifc.data_in = (i < OS) ? 1'b0 : w[7 - (i / OS - 1)];
      end
    end
    chk("midreset active_before", (act_cnt > 0) ? 1 : 0, 1);
    chk("midreset done_before", done_cnt, 0);
    rst = 1'b1;
    #1;
    chk("midreset data_out", ifc.data_out, 8'h00);
    chk("midreset rx_active", ifc.rx_active, 1'b0);
    chk("midreset rx_done", ifc.rx_done, 1'b0);
    chk("midreset perr", ifc.parity_error, 1'b0);
    chk("midreset serr", ifc.stop_error, 1'b0);
    @(negedge clk);
    ifc.data_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_high(4);
    v = '{2'b00, 1'b0, 1'b1, 8'h3C, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b0};
    run_frame(v, OS, 1'b1, -1, "after_reset");

    // data_length flipped 1->0 during data bit 3: frame still 8 bits.
    v = '{2'b00, 1'b0, 1'b1, 8'h96, 1'b0, 2'b01, 8'h96, 1'b0, 1'b0};
    run_frame(v, OS, 1'b1, 3 * OS + 5, "cfg_flip");
    chk("cfg_flip length_now", ifc.data_length, 1'b0);
    v = '{2'b00, 1'b0, 1'b0, 8'h55, 1'b0, 2'b01, 8'h55, 1'b0, 1'b0};
    run_frame(v, OS, 1'b1, -1, "cfg_next_7bit");

    // Back-to-back 8N1 frames with no idle gap.
    v = '{2'b00, 1'b0, 1'b1, 8'hE1, 1'b0, 2'b01, 8'hE1, 1'b0, 1'b0};
    run_frame(v, 0, 1'b1, -1, "b2b_first");
    v = '{2'b00, 1'b0, 1'b1, 8'h1E, 1'b0, 2'b01, 8'h1E, 1'b0, 1'b0};
    run_frame(v, 0, 1'b1, -1, "b2b_second");
    idle_high(OS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
